alu_seq: RTL
============

# alu_seq

Parametrised, registered ALU with a valid/ready operation handshake, an accumulator register, a four-state control FSM (READY / ARITH / LOGIC / ERROR) and a sticky error state. It sits between the instruction decode and the register file. It executes one operation at a time and optionally performs an iterative multi-cycle multiply. It writes each successful result into its accumulator, which can be selected as operand A of the next operation.

## Interface
- `WIDTH`, default 8: operand, result and accumulator width in bits. Must be at least 4 and a power of two.
- `clk` input, 1 bit: single clock; all state changes on the rising edge.
- `rst` input, 1 bit: synchronous reset, active-high.
- `op_valid` input, 1 bit: operation request.
- `op_ready` output, 1 bit: high only in READY; an operation is accepted on a rising edge where `op_valid && op_ready`.
- `funct` input, 4 bits: operation select.
- `a` input, WIDTH bits: operand A.
- `b` input, WIDTH bits: operand B.
- `use_acc` input, 1 bit: when high, the accumulator replaces `a` as operand A.
- `err_clr` input, 1 bit: leaves ERROR for READY.
- `result` output, WIDTH bits: last computed result, held until the next completion.
- `res_valid` output, 1 bit: one-cycle pulse on completion, including completions that enter ERROR.
- `carry` output, 1 bit: carry, borrow or shift-out flag of the last operation.
- `overflow` output, 1 bit: overflow flag of the last operation.
- `error` output, 1 bit: high while in ERROR.
- `state` output, 2 bits: READY=0, ARITH=1, LOGIC=2, ERROR=3.
- `acc` output, WIDTH bits: accumulator.

## Operation
- funct codes:
  - 0 ADD, 1 SUB, 2 SHL, 3 SHR (arithmetic, ARITH state).
  - 4 AND, 5 OR, 6 XOR, 7 NOT(A), 8 NAND, 9 NOR, 10 XNOR (logic, LOGIC state).
  - 11 MUL (ARITH state).
  - 12–15 illegal.
- On accept:
  - Operand A (`a` or `acc`), `b` and `funct` are latched.
  - READY→ARITH for codes 0–3 and 11; READY→LOGIC for codes 4–10; READY→ERROR for illegal codes.
  - An illegal code sets `error`, pulses `res_valid` and leaves `result` and the flags unchanged.
- ADD/SUB:
  - `result` is the modulo-2^WIDTH sum or difference.
  - `carry` is the unsigned carry-out or borrow.
  - `overflow` is two's-complement signed overflow.
- SHL/SHR:
  - Logical shift by the full value of `b`; if `b` ≥ WIDTH, `result` is 0.
  - `carry` = OR of all bits shifted out; `overflow` = 0.
- MUL:
  - Unsigned shift-add, one partial product per cycle.
  - `result` is the low WIDTH bits; `overflow` = OR of the high WIDTH bits; `carry` = 0.
- Logic ops: `carry` = 0 and `overflow` = 0.
- Completion:
  - If ARITH finishes with `overflow` or `carry` set: `result` and flags are updated, `acc` is NOT written, and the FSM enters ERROR.
  - Otherwise `acc` ← `result` and the FSM enters READY.
  - LOGIC always completes to READY.
- ERROR:
  - `op_ready` = 0 and `error` = 1; `acc` and `result` hold.
  - `err_clr` high on an edge → READY.
  - `err_clr` is ignored in any other state.
- Reset values: `state` = READY, `acc` = 0, `result` = 0, `carry` = 0, `overflow` = 0, `res_valid` = 0, `error` = 0. `op_ready` = 1 the cycle after reset deasserts.
- Reset mid-operation (including mid-multiply) aborts with no `res_valid` and no `acc` write.

## Timing
- Single-cycle ops:
  - Accept at edge N; ARITH or LOGIC during cycle N..N+1.
  - `result`, flags and `acc` update at edge N+1; `res_valid` is high for the cycle following edge N+1.
  - `state` returns to READY (or ERROR) at edge N+1.
  - Maximum throughput is one operation per 2 cycles.
- MUL:
  - Accept at edge N; completes at edge N+WIDTH with `res_valid` in the following cycle.
  - `op_ready` is low for WIDTH cycles.
- `op_valid` while `op_ready` = 0 is ignored; the requester holds it.
- `res_valid` and `op_ready` are both high in the cycle after a successful completion, so a new op may be accepted on that edge. With `use_acc` = 1 it uses the just-written `acc`.
- In ERROR, `err_clr` and `op_valid` high together: the FSM goes to READY and the op is not accepted.

## Configuration
- `ALU_SEQ_MULT_EN` defined: funct 11 is MUL, implemented through the iterative multiplier.
- `ALU_SEQ_MULT_EN` undefined: funct 11 is illegal (accept → ERROR with `res_valid` pulse), and the multiplier and its counter are not instantiated.

## Structure
- Package `alu_seq_pkg` holds:
  - the funct code constants/enum `alu_funct_e`;
  - the state enum `alu_state_e` (READY=0, ARITH=1, LOGIC=2, ERROR=3);
  - a function `is_arith(funct)`.
- Sub-module `alu_seq_mult`: WIDTH-parameterised iterative shift-add multiplier.
  - Start/busy/done handshake and a $clog2(WIDTH)+1-bit cycle counter.
  - Produces a 2·WIDTH-bit product.
  - Instantiated only under `ALU_SEQ_MULT_EN`.
- Top level holds the FSM, the operand latches, the single-cycle datapath and the accumulator.

## Test plan (WIDTH=8)
- Reset, then ADD a=0x12, b=0x34: `res_valid` 2 cycles after the request cycle, `result` = `acc` = 0x46, carry=0, overflow=0, `state` back to READY.
- ADD a=0x7F, b=0x01: `result` = 0x80, overflow=1, `acc` unchanged, `error`=1, `op_ready`=0. Then `err_clr` pulse → READY with `acc` still at its old value.
- SHL a=0x81, b=1: `result` = 0x02, carry=1 → ERROR. SHR a=0x80, b=9: `result` = 0x00, carry=1 → ERROR.
- XOR a=0xF0, b=0xFF → `acc` = 0x0F. Back-to-back NOT with `use_acc`=1 → `acc` = 0xF0, accepted on the `res_valid` cycle.
- With `ALU_SEQ_MULT_EN`: MUL 0x0F×0x0F → `result` = 0xE1 after 8 busy cycles, `acc` = 0xE1. MUL 0x10×0x10 → overflow=1 → ERROR. Without the macro: funct 11 → ERROR on the next edge.
- Reset asserted at cycle 3 of a MUL: no `res_valid`, `acc` = 0, READY the cycle after reset deasserts. funct 13 → ERROR, `result` unchanged.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared funct codes, FSM state encoding and decode helpers for alu_seq.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        F_ADD  = 4'd0,
        F_SUB  = 4'd1,
        F_SHL  = 4'd2,
        F_SHR  = 4'd3,
        F_AND  = 4'd4,
        F_OR   = 4'd5,
        F_XOR  = 4'd6,
        F_NOT  = 4'd7,
        F_NAND = 4'd8,
        F_NOR  = 4'd9,
        F_XNOR = 4'd10,
        F_MUL  = 4'd11
    } alu_funct_e;

    typedef enum logic [1:0] {
        ST_READY = 2'd0,
        ST_ARITH = 2'd1,
        ST_LOGIC = 2'd2,
        ST_ERROR = 2'd3
    } alu_state_e;

    function automatic logic is_arith(input logic [3:0] funct);
        return (funct <= 4'd3) || (funct == 4'd11);
    endfunction

    function automatic logic is_logic(input logic [3:0] funct);
        return (funct >= 4'd4) && (funct <= 4'd10);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operation request / result bundle between the decode stage (master) and alu_seq (slave).
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             op_valid;
    logic             op_ready;
    logic [3:0]       funct;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             use_acc;
    logic             err_clr;
    logic [WIDTH-1:0] result;
    logic             res_valid;
    logic             carry;
    logic             overflow;
    logic             error;
    logic [1:0]       state;
    logic [WIDTH-1:0] acc;

    modport master (
        output op_valid, funct, a, b, use_acc, err_clr,
        input  op_ready, result, res_valid, carry, overflow, error, state, acc
    );

    modport slave (
        input  op_valid, funct, a, b, use_acc, err_clr,
        output op_ready, result, res_valid, carry, overflow, error, state, acc
    );
endinterface

// File: rtl/alu_seq_mult.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle, WIDTH cycles per product.
module alu_seq_mult #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [CNT_W-1:0]   cnt_p0;
    logic [2*WIDTH-1:0] mcand_p0;
    logic [2*WIDTH-1:0] prod_p0;
    logic [WIDTH-1:0]   mplier_p0;
    logic [2*WIDTH-1:0] prod_next;

    // The final partial product is folded in combinationally so the full
    // product is visible during the last busy cycle.
    assign prod_next = prod_p0 + (mplier_p0[0] ? mcand_p0 : '0);
    assign done      = busy && (cnt_p0 == CNT_W'(WIDTH - 1));
    assign product   = prod_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= 1'b0;
            cnt_p0 <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt_p0 <= '0;
        end else if (busy) begin
            cnt_p0 <= cnt_p0 + CNT_W'(1);
            if (done) busy <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            mcand_p0  <= {{WIDTH{1'b0}}, mcand};
            mplier_p0 <= mplier;
            prod_p0   <= '0;
        end else if (busy) begin
            prod_p0   <= prod_next;
            mcand_p0  <= mcand_p0 << 1;
            mplier_p0 <= mplier_p0 >> 1;
        end
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with accumulator and READY/ARITH/LOGIC/ERROR control FSM.
// Define ALU_SEQ_MULT_EN to make funct 11 a MUL through alu_seq_mult; otherwise it is illegal.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic      clk,
    input logic      rst,
    alu_seq_if.slave bus
);
    localparam int SH_W = $clog2(WIDTH);

`ifdef ALU_SEQ_MULT_EN
    localparam bit MULT_EN = 1'b1;
`else
    localparam bit MULT_EN = 1'b0;
`endif

    alu_state_e       state_p0, next_state;
    logic [3:0]       funct_p0;
    logic [WIDTH-1:0] opa_p0, opb_p0;
    logic [WIDTH-1:0] result_p1, acc_p1;
    logic             carry_p1, ovf_p1, vld_p1;
    logic [WIDTH-1:0] opa_sel, alu_res;
    logic             alu_c, alu_v;
    logic             accept, req_arith, req_logic, arith_fin, complete, fail;
    logic             ready_c, error_c;

    // Returns {overflow, carry, result} for every single-cycle funct.
    function automatic logic [WIDTH+1:0] eval_op(input logic [3:0] f,
                                                 input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
        logic [WIDTH:0]     sum;
        logic [2*WIDTH-1:0] sh;
        logic [WIDTH-1:0]   r;
        logic               c, v, big;
        r   = '0;
        c   = 1'b0;
        v   = 1'b0;
        sum = '0;
        sh  = '0;
        big = |y[WIDTH-1:SH_W];
        case (f)
            F_ADD: begin
                sum = {1'b0, x} + {1'b0, y};
                r   = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
            end
            F_SUB: begin
                sum = {1'b0, x} - {1'b0, y};
                r   = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
            end
            F_SHL: begin
                sh = {{WIDTH{1'b0}}, x} << y[SH_W-1:0];
                r  = big ? '0 : sh[WIDTH-1:0];
                c  = big ? |x : |sh[2*WIDTH-1:WIDTH];
            end
            F_SHR: begin
                sh = {x, {WIDTH{1'b0}}} >> y[SH_W-1:0];
                r  = big ? '0 : sh[2*WIDTH-1:WIDTH];
                c  = big ? |x : |sh[WIDTH-1:0];
            end
            F_AND:   r = x & y;
            F_OR:    r = x | y;
            F_XOR:   r = x ^ y;
            F_NOT:   r = ~x;
            F_NAND:  r = ~(x & y);
            F_NOR:   r = ~(x | y);
            F_XNOR:  r = ~(x ^ y);
            default: r = '0;
        endcase
        return {v, c, r};
    endfunction

    assign accept    = bus.op_valid && (state_p0 == ST_READY);
    assign opa_sel   = bus.use_acc ? acc_p1 : bus.a;
    assign req_arith = is_arith(bus.funct) && (MULT_EN || (bus.funct != F_MUL));
    assign req_logic = is_logic(bus.funct);

`ifdef ALU_SEQ_MULT_EN
    logic               mul_start, mul_busy, mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    assign mul_start = accept && (bus.funct == F_MUL);

    alu_seq_mult #(.WIDTH(WIDTH)) u_mult (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .mcand   (opa_sel),
        .mplier  (bus.b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_prod)
    );

    assign arith_fin = (funct_p0 != F_MUL) || (mul_busy && mul_done);
`else
    assign arith_fin = 1'b1;
`endif

    always_comb begin
        {alu_v, alu_c, alu_res} = eval_op(funct_p0, opa_p0, opb_p0);
`ifdef ALU_SEQ_MULT_EN
        if (funct_p0 == F_MUL) begin
            alu_res = mul_prod[WIDTH-1:0];
            alu_c   = 1'b0;
            alu_v   = |mul_prod[2*WIDTH-1:WIDTH];
        end
`endif
    end

    assign complete = ((state_p0 == ST_ARITH) && arith_fin) || (state_p0 == ST_LOGIC);
    assign fail     = (state_p0 == ST_ARITH) && (alu_c || alu_v);

    always_ff @(posedge clk) begin
        if (rst) state_p0 <= ST_READY;
        else     state_p0 <= next_state;
    end

    always_comb begin
        next_state = state_p0;
        ready_c    = 1'b0;
        error_c    = 1'b0;
        unique case (state_p0)
            ST_READY: begin
                ready_c = 1'b1;
                if (bus.op_valid) begin
                    if (req_arith)      next_state = ST_ARITH;
                    else if (req_logic) next_state = ST_LOGIC;
                    else                next_state = ST_ERROR;
                end
            end
            ST_ARITH: if (arith_fin) next_state = fail ? ST_ERROR : ST_READY;
            ST_LOGIC: next_state = ST_READY;
            ST_ERROR: begin
                error_c = 1'b1;
                if (bus.err_clr) next_state = ST_READY;
            end
            default:  next_state = ST_READY;
        endcase
    end

    // Stage p0: operand latch on accept
    always_ff @(posedge clk) begin
        if (accept) begin
            funct_p0 <= bus.funct;
            opa_p0   <= opa_sel;
            opb_p0   <= bus.b;
        end
    end

    // Stage p1: result, flags and accumulator write-back
    always_ff @(posedge clk) begin
        if (rst) begin
            result_p1 <= '0;
            carry_p1  <= 1'b0;
            ovf_p1    <= 1'b0;
            acc_p1    <= '0;
            vld_p1    <= 1'b0;
        end else begin
            vld_p1 <= complete || (accept && !req_arith && !req_logic);
            if (complete) begin
                result_p1 <= alu_res;
                carry_p1  <= alu_c;
                ovf_p1    <= alu_v;
                if (!fail) acc_p1 <= alu_res;
            end
        end
    end

    assign bus.op_ready  = ready_c;
    assign bus.error     = error_c;
    assign bus.state     = state_p0;
    assign bus.result    = result_p1;
    assign bus.carry     = carry_p1;
    assign bus.overflow  = ovf_p1;
    assign bus.res_valid = vld_p1;
    assign bus.acc       = acc_p1;
endmodule
